count_capture_fifo: RTL and testbench
=====================================

Name: count_capture_fifo

Overview:
- Downstream consumer of the BinaryCounter stage.
- Samples the 6-bit `count` bus whenever `result` is high and tags each sample with a wrap flag.
- Buffers tagged records in a first-word-fall-through FIFO and presents them on a valid/ready output for the next stage.
- Tracks dropped samples when the FIFO is full.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- count_in  input  6  count value from the BinaryCounter stage.
- result_in  input  1  capture strobe from the BinaryCounter stage; a high level requests a capture that cycle.
- out_ready  input  1  downstream accepts the head record this cycle.
- out_valid  output  1  head record is valid.
- out_data  output  7  head record, {wrap, count}.
- level  output  $clog2(DEPTH)+1  current number of stored entries.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- drop_count  output  DROP_W  number of rejected captures, saturating.
- overflow  output  1  sticky flag, set on the first drop.

Behaviour:
- Interface: one clock (`clock`); reset is synchronous and active-high (`reset`).
- Reset, sampled at a rising edge, forces all of the following:
  - level = 0, empty = 1, full = 0, out_valid = 0.
  - out_data = 0, drop_count = 0, overflow = 0.
  - prev_count = 0.
  - Read and write pointers = 0.
- Reset mid-operation discards all stored entries with no drain.
- Reset has priority over push and pop in the same cycle.
- prev_count register:
  - Loads count_in every cycle, regardless of result_in.
  - wrap = (count_in < prev_count), unsigned 6-bit compare, evaluated combinationally in the capture cycle.
- Push request: result_in == 1. The record written is {wrap, count_in}.
- Pop: out_valid && out_ready. Pop when empty is impossible because out_valid = 0.
- First-word-fall-through output:
  - out_valid = !empty.
  - out_data = memory[rd_ptr], taken from the registered pointer.
  - When not valid, out_data holds its last value; it is 0 after reset.
- Latency: a record pushed at edge N appears on out_data with out_valid = 1 after edge N; push-to-visible is one cycle.
- Simultaneous-event cases:
  - Empty + push + out_ready: no pop (out_valid = 0). Push occurs; level becomes 1.
  - Not empty, not full, push + pop: both occur; level unchanged; order preserved.
  - Full + push + pop: push accepted, pop occurs, level stays DEPTH, no drop.
  - Full + push, no pop: record discarded, drop_count += 1 (saturates at 2^DROP_W-1), overflow = 1.
- overflow stays set until reset.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- level = write count − read count, maintained as a registered counter.
- full and empty are registered or derived from level; both must be glitch-free at edges.
- Data ordering is strictly FIFO; no reordering and no duplication.

Test Plan:
- Reset with result_in = 1 and count_in = 6'h15 held → after edge: level = 0, out_valid = 0, out_data = 0, drop_count = 0, overflow = 0.
- Counts 3, 4, 5 on consecutive cycles with result_in = 1, out_ready = 0 → level = 3; then out_ready = 1 → out_data sequence 7'h03, 7'h04, 7'h05, then out_valid = 0.
- count_in 63 (result_in = 0), then 0 (result_in = 1) → out_data = 7'h40 (wrap = 1). Count 0 then 1 with result_in = 1 → second record 7'h01.
- Fill 8 entries (counts 10..17), out_ready = 0, then 3 more pushes with counts 18..20 → level = 8, full = 1, drop_count = 3, overflow = 1. Drain yields 10..17 only.
- Full FIFO, push count 30 with out_ready = 1 → level stays 8, drop_count unchanged, record 30 is the last out.
- Reset asserted with level = 5 → next cycle level = 0, empty = 1, overflow = 0. A push two cycles later is the first record out.

Source files
------------

// File: rtl/count_capture_fifo.sv
// count_capture_fifo
// Captures the 6-bit count bus from the BinaryCounter stage whenever the
// result strobe is high. Each sample is tagged with a wrap flag, which is set
// when the count went backwards since the previous cycle. Tagged records are
// buffered in a first-word-fall-through FIFO and offered on a valid/ready
// output. Captures refused because the FIFO is full are counted in a
// saturating drop counter and raise a sticky overflow flag.
module count_capture_fifo #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [5:0]               count_in,
    input  logic                     result_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [6:0]               out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [DROP_W-1:0]        drop_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Storage and bookkeeping state
    logic [6:0]        r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_full;
    logic              r_empty;
    logic [6:0]        r_out_data;
    logic [DROP_W-1:0] r_drop_count;
    logic              r_overflow;
    logic [5:0]        r_prev_count;

    // Combinational decisions for the current cycle
    logic              w_wrap;
    logic [6:0]        w_din;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [AW-1:0]     w_rd_next;
    logic [LW-1:0]     w_level_next;
    logic [6:0]        w_head_next;

    // Decide push/pop/drop and work out what the head will be after this edge.
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    always_comb begin
        w_wrap    = (count_in < r_prev_count);
        w_din     = {w_wrap, count_in};
        w_pop     = !r_empty && out_ready;
        w_push    = result_in && (!r_full || w_pop);
        w_drop    = result_in && r_full && !w_pop;
        w_rd_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LW'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - LW'(1);
        end

        // The record being written this cycle becomes the head when it lands
        // exactly at the next read pointer (FIFO empty after this edge's pop).
        if (w_push && (r_wr_ptr == w_rd_next)) begin
            w_head_next = w_din;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Record storage; left unreset so it can map onto plain RAM
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= w_din;
        end
    end

    // Pointers, occupancy, flags, registered head record and drop accounting
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_out_data   <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
            r_prev_count <= '0;
        end else begin
            r_prev_count <= count_in;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= w_level_next;
            r_full   <= (w_level_next == LW'(DEPTH));
            r_empty  <= (w_level_next == '0);
            // Head is held when the FIFO drains so the last record stays visible
            if (w_level_next != '0) begin
                r_out_data <= w_head_next;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != {DROP_W{1'b1}}) begin
                    r_drop_count <= r_drop_count + DROP_W'(1);
                end
            end
        end
    end

    assign out_valid  = !r_empty;
    assign out_data   = r_out_data;
    assign level      = r_level;
    assign full       = r_full;
    assign empty      = r_empty;
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Testbench for count_capture_fifo: directed steps from the test plan followed
// by random traffic, all checked against a queue-based reference model.
module tb_count_capture_fifo;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 8;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [5:0]             count_in;
    logic                   result_in;
    logic                   out_ready;
    logic                   out_valid;
    logic [6:0]             out_data;
    logic [$clog2(DEPTH):0] level;
    logic                   full;
    logic                   empty;
    logic [DROP_W-1:0]      drop_count;
    logic                   overflow;

    count_capture_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .count_in   (count_in),
        .result_in  (result_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [6:0] m_q[$];
    logic [5:0] m_prev;
    int         m_drops;
    logic       m_ovf;
    logic [6:0] m_out;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge with the given inputs
    task automatic model_edge(input logic rst, input logic [5:0] cin,
                              input logic res, input logic rdy);
        logic did_pop;
        if (rst) begin
            m_q.delete();
            m_prev  = 6'd0;
            m_drops = 0;
            m_ovf   = 1'b0;
            m_out   = 7'd0;
        end else begin
            did_pop = (m_q.size() > 0) && rdy;
            if (did_pop) void'(m_q.pop_front());
            if (res) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({(cin < m_prev), cin});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < (1 << DROP_W) - 1) m_drops++;
                end
            end
            m_prev = cin;
            if (m_q.size() > 0) m_out = m_q[0];
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_q.size() > 0));
        chk({tag, ".data"},  32'(out_data),  32'(m_out));
        chk({tag, ".level"}, 32'(level),     32'(m_q.size()));
        chk({tag, ".full"},  32'(full),      32'(m_q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty),     32'(m_q.size() == 0));
        chk({tag, ".drops"}, 32'(drop_count), 32'(m_drops));
        chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    endtask

    // Apply inputs, take one edge, update the model and check 1 time unit later
    task automatic step(input string tag, input logic rst, input logic [5:0] cin,
                        input logic res, input logic rdy);
        reset     = rst;
        count_in  = cin;
        result_in = res;
        out_ready = rdy;
        @(posedge clock);
        model_edge(rst, cin, res, rdy);
        #1;
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH && m_q.size() > 0; i++) begin
            step(tag, 1'b0, 6'd0, 1'b0, 1'b1);
        end
        chk({tag, ".drained"}, 32'(empty), 32'd1);
    endtask

    initial begin
        reset = 1'b1; count_in = 6'h15; result_in = 1'b1; out_ready = 1'b0;
        m_prev = 6'd0; m_drops = 0; m_ovf = 1'b0; m_out = 7'd0;

        // Reset with a capture request held
        step("rst", 1'b1, 6'h15, 1'b1, 1'b0);
        step("rst", 1'b1, 6'h15, 1'b1, 1'b0);
        chk("rst.level", 32'(level), 32'd0);
        chk("rst.data",  32'(out_data), 32'd0);
        chk("rst.valid", 32'(out_valid), 32'd0);

        // Three captures, then drain in order
        step("p3", 1'b0, 6'd3, 1'b1, 1'b0);
        chk("p3.visible", 32'(out_data), 32'h03);
        step("p4", 1'b0, 6'd4, 1'b1, 1'b0);
        step("p5", 1'b0, 6'd5, 1'b1, 1'b0);
        chk("p345.level", 32'(level), 32'd3);
        step("d1", 1'b0, 6'd5, 1'b0, 1'b1);
        chk("d1.data", 32'(out_data), 32'h04);
        step("d2", 1'b0, 6'd5, 1'b0, 1'b1);
        chk("d2.data", 32'(out_data), 32'h05);
        step("d3", 1'b0, 6'd5, 1'b0, 1'b1);
        chk("d3.valid", 32'(out_valid), 32'd0);
        chk("d3.hold", 32'(out_data), 32'h05);

        // Wrap detection
        step("w63", 1'b0, 6'd63, 1'b0, 1'b1);
        step("w0",  1'b0, 6'd0,  1'b1, 1'b1);
        chk("w0.data", 32'(out_data), 32'h40);
        step("n0",  1'b0, 6'd0,  1'b1, 1'b1);
        chk("n0.data", 32'(out_data), 32'h00);
        step("n1",  1'b0, 6'd1,  1'b1, 1'b1);
        chk("n1.data", 32'(out_data), 32'h01);
        drain("wdrain");

        // Overfill: 10..17 stored, 18..20 dropped
        for (int i = 10; i <= 20; i++) step("fill", 1'b0, 6'(i), 1'b1, 1'b0);
        chk("fill.level", 32'(level), 32'd8);
        chk("fill.full",  32'(full), 32'd1);
        chk("fill.drops", 32'(drop_count), 32'd3);
        chk("fill.ovf",   32'(overflow), 32'd1);
        for (int i = 10; i <= 17; i++) begin
            chk("fill.order", 32'(out_data[5:0]), 32'(i));
            step("fdrain", 1'b0, 6'd0, 1'b0, 1'b1);
        end
        chk("fill.empty", 32'(empty), 32'd1);

        // Full + push + pop: accepted, no drop
        for (int i = 21; i <= 28; i++) step("fill2", 1'b0, 6'(i), 1'b1, 1'b0);
        step("fp", 1'b0, 6'd30, 1'b1, 1'b1);
        chk("fp.level", 32'(level), 32'd8);
        chk("fp.drops", 32'(drop_count), 32'd3);
        for (int i = 0; i < 7; i++) step("fpdrain", 1'b0, 6'd0, 1'b0, 1'b1);
        chk("fp.last", 32'(out_data), 32'h1e);
        drain("fpdrain");

        // Reset mid-operation
        for (int i = 0; i < 5; i++) step("pre", 1'b0, 6'(40 + i), 1'b1, 1'b0);
        step("midrst", 1'b1, 6'd0, 1'b0, 1'b0);
        chk("midrst.level", 32'(level), 32'd0);
        chk("midrst.ovf", 32'(overflow), 32'd0);
        step("idle", 1'b0, 6'd2, 1'b0, 1'b0);
        step("first", 1'b0, 6'd9, 1'b1, 1'b0);
        chk("first.data", 32'(out_data), 32'h09);
        drain("rdrain");

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step("rnd", ($urandom_range(0, 199) == 0), 6'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
